signed_step_counter: RTL and testbench
======================================

SIGNED_STEP_COUNTER -- requirements
Module: signed_step_counter

Interface
REQ-001 The block SHALL have parameter NBITS, default 3, giving the two's-complement width of the counter.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the number of consecutive stable samples that qualify a button press or release; legal range 2..255.
REQ-003 clk_2  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 inc  input  1  raw increment button level (SWI bit), unsynchronised, bouncy.
REQ-006 dec  input  1  raw decrement button level (SWI bit), unsynchronised, bouncy.
REQ-007 load  input  1  synchronous load strobe, level-sampled each cycle.
REQ-008 load_val  input  NBITS  two's-complement value to load.
REQ-009 value  output  NBITS  registered two's-complement count; feeds the seven-segment digit decoder.
REQ-010 magnitude  output  NBITS  registered absolute value of value; -4 gives 4.
REQ-011 negative  output  1  registered; high when value < 0; drives the decimal-point minus sign (SEG[7]).
REQ-012 wrap  output  1  registered one-cycle pulse on a boundary event (REQ-020).

Function
REQ-013 Each of inc and dec SHALL pass through a two-flop synchroniser, then an independent debounce FSM with states IDLE, ARM, PRESSED, RELEASE and a counter of DEBOUNCE_CYCLES width.
REQ-014 IDLE: synced input high -> ARM, cnt=1; otherwise stay.
REQ-015 ARM: input high -> cnt+1, and on reaching DEBOUNCE_CYCLES -> PRESSED and emit a one-cycle step pulse; input low -> IDLE, cnt=0.
REQ-016 PRESSED: input low -> RELEASE, cnt=1; high -> stay, no further pulses (one step per press, no auto-repeat).
REQ-017 RELEASE: input low -> cnt+1, and on reaching DEBOUNCE_CYCLES -> IDLE; input high -> PRESSED, no pulse.
REQ-018 value SHALL change on the clock edge after the step pulse; the total latency is 2 (sync) + DEBOUNCE_CYCLES + 1 edges from the first edge at which the raw input is high.
REQ-019 Priority per cycle: load > (inc and dec pulses together: no change, wrap=0) > single inc pulse (+1) > single dec pulse (-1) > hold.
REQ-020 Boundary: +1 at 2^(NBITS-1)-1 and -1 at -2^(NBITS-1) are boundary events; wrap=1 for exactly one cycle together with the value update.
REQ-021 load SHALL set value=load_val on the next edge with wrap=0, and SHALL NOT disturb the debounce FSMs; a step pulse coinciding with load is discarded.
REQ-022 magnitude and negative SHALL always be consistent with value in the same cycle (derived from next-value, all registered).

Reset
REQ-023 While reset is sampled high: value=0, magnitude=0, negative=0, wrap=0, both FSMs IDLE, cnt=0, synchroniser flops=0.
REQ-024 Reset asserted mid-debounce or mid-press SHALL abort it; a button still held at reset release SHALL be re-qualified from IDLE and counts as a new press.

Configuration
REQ-025 Macro SIGNED_STEP_SATURATE_EN: when defined, boundary events hold value at the limit (3 stays 3, -4 stays -4) and still pulse wrap; when undefined, value wraps modulo 2^NBITS (3 -> -4, -4 -> 3).

Structure
REQ-026 A shared package loac_pkg SHALL hold the debounce state enum (IDLE, ARM, PRESSED, RELEASE) and the default NBITS constant.
REQ-027 The debounce FSM plus synchroniser SHALL be a sub-module, button_debounce, instantiated twice (inc, dec).

Verification
REQ-028 Reset, then hold inc high 10 cycles, release 10 cycles -> value 0->1 exactly at edge 7 (DEBOUNCE_CYCLES=4), one step only, negative=0.
REQ-029 inc glitch high 2 cycles then low -> no step; value stays 0.
REQ-030 From value 3, one inc press -> wrap undefined: value=-4 (3'b100), magnitude=4, negative=1, wrap pulse 1 cycle; with SIGNED_STEP_SATURATE_EN: value stays 3, wrap pulses.
REQ-031 From 0, dec press -> value=-1 (3'b111), magnitude=1, negative=1; inc and dec pressed identically and simultaneously -> no change.
REQ-032 load=1, load_val=3'b110 during an inc ARM phase -> value=-2 next edge, and the inc step completing in that same cycle is dropped.
REQ-033 Assert reset while inc held in PRESSED with value=2 -> all outputs 0; keep inc held after reset release -> value=1 after full re-qualification latency.

Source files
------------

// File: rtl/loac_pkg.sv
// Shared types and defaults for the signed step counter and its button debouncers.
package loac_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        PRESSED = 2'd2,
        RELEASE = 2'd3
    } debounce_state_t;

    localparam int NBITS_DEFAULT    = 3;
    localparam int DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus press/release debounce FSM; emits one step pulse per qualified press.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | button released and qualified; waiting for a high sample
// ARM     | counting consecutive high samples toward a qualified press
// PRESSED | press qualified and step emitted; waiting for a low sample
// RELEASE | counting consecutive low samples toward a qualified release
module button_debounce
    import loac_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_step
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic            r_sync1;
    logic            r_sync2;
    debounce_state_t r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_step;
    logic [CW-1:0]   w_cnt_inc;

    assign w_cnt_inc = r_cnt + CW'(1);
    assign o_step    = r_step;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_step  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_step  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (r_sync2) begin
                        r_state <= ARM;
                        r_cnt   <= CW'(1);
                    end
                end
                ARM: begin
                    if (!r_sync2) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                        r_step  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!r_sync2) begin
                        r_state <= RELEASE;
                        r_cnt   <= CW'(1);
                    end
                end
                RELEASE: begin
                    // A high sample here is bounce on release, so no new step.
                    if (r_sync2) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (w_cnt_inc == CNT_MAX) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/signed_step_counter.sv
// Debounced up/down two's-complement counter with load, magnitude/sign outputs and boundary pulse.
// Define SIGNED_STEP_SATURATE_EN to hold at the limits instead of wrapping.
module signed_step_counter
    import loac_pkg::*;
#(
    parameter int NBITS           = NBITS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [NBITS-1:0] load_val,
    output logic [NBITS-1:0] value,
    output logic [NBITS-1:0] magnitude,
    output logic             negative,
    output logic             wrap
);

    localparam logic [NBITS-1:0] MAX_POS = {1'b0, {(NBITS-1){1'b1}}};
    localparam logic [NBITS-1:0] MIN_NEG = {1'b1, {(NBITS-1){1'b0}}};

    logic             w_inc_step;
    logic             w_dec_step;
    logic [NBITS-1:0] w_next;
    logic [NBITS-1:0] w_next_mag;
    logic             w_wrap;

    logic [NBITS-1:0] r_value;
    logic [NBITS-1:0] r_magnitude;
    logic             r_negative;
    logic             r_wrap;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
        .i_clk   (clk_2),
        .i_reset (reset),
        .i_btn   (inc),
        .o_step  (w_inc_step)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_db (
        .i_clk   (clk_2),
        .i_reset (reset),
        .i_btn   (dec),
        .o_step  (w_dec_step)
    );

    always_comb begin
        w_next = r_value;
        w_wrap = 1'b0;
        if (load) begin
            w_next = load_val;
        end else if (w_inc_step && w_dec_step) begin
            w_next = r_value;
        end else if (w_inc_step) begin
            if (r_value == MAX_POS) begin
                w_wrap = 1'b1;
`ifdef SIGNED_STEP_SATURATE_EN
                w_next = MAX_POS;
`else
                w_next = MIN_NEG;
`endif
            end else begin
                w_next = r_value + NBITS'(1);
            end
        end else if (w_dec_step) begin
            if (r_value == MIN_NEG) begin
                w_wrap = 1'b1;
`ifdef SIGNED_STEP_SATURATE_EN
                w_next = MIN_NEG;
`else
                w_next = MAX_POS;
`endif
            end else begin
                w_next = r_value - NBITS'(1);
            end
        end
    end

    // The most negative value negates to itself, which reads correctly as its unsigned magnitude.
    assign w_next_mag = w_next[NBITS-1] ? (~w_next + NBITS'(1)) : w_next;

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_value     <= '0;
            r_magnitude <= '0;
            r_negative  <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_value     <= w_next;
            r_magnitude <= w_next_mag;
            r_negative  <= w_next[NBITS-1];
            r_wrap      <= w_wrap;
        end
    end

    assign value     = r_value;
    assign magnitude = r_magnitude;
    assign negative  = r_negative;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_signed_step_counter.sv
// Directed bench for signed_step_counter with a cycle-stamped scoreboard of expected outputs.
module tb_signed_step_counter;

    localparam int NB = 3;

    logic          clk_2 = 1'b0;
    logic          reset;
    logic          inc;
    logic          dec;
    logic          load;
    logic [NB-1:0] load_val;
    logic [NB-1:0] value;
    logic [NB-1:0] magnitude;
    logic          negative;
    logic          wrap;

    typedef struct packed {
        int            due;
        logic [NB-1:0] v;
        logic          w;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_err = 0;

    exp_t          e_chk;
    string         t_chk;
    logic [NB-1:0] m_chk;
    logic          n_chk;

    signed_step_counter #(.NBITS(NB), .DEBOUNCE_CYCLES(4)) dut (
        .clk_2     (clk_2),
        .reset     (reset),
        .inc       (inc),
        .dec       (dec),
        .load      (load),
        .load_val  (load_val),
        .value     (value),
        .magnitude (magnitude),
        .negative  (negative),
        .wrap      (wrap)
    );

    always #5 clk_2 = ~clk_2;

    always @(posedge clk_2) cyc <= cyc + 1;

    function automatic logic [NB-1:0] f_mag(input logic [NB-1:0] v);
        int s;
        s = int'($signed(v));
        return NB'((s < 0) ? -s : s);
    endfunction

    always @(negedge clk_2) begin
        while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            e_chk = sb_q.pop_front();
            t_chk = tag_q.pop_front();
            m_chk = f_mag(e_chk.v);
            n_chk = $signed(e_chk.v) < 0;
            n_checks += 4;
            assert (value === e_chk.v) else begin
                n_err++;
                $error("FAIL %s value @cyc %0d: got %b want %b", t_chk, cyc, value, e_chk.v);
            end
            assert (magnitude === m_chk) else begin
                n_err++;
                $error("FAIL %s magnitude @cyc %0d: got %b want %b", t_chk, cyc, magnitude, m_chk);
            end
            assert (negative === n_chk) else begin
                n_err++;
                $error("FAIL %s negative @cyc %0d: got %b want %b", t_chk, cyc, negative, n_chk);
            end
            assert (wrap === e_chk.w) else begin
                n_err++;
                $error("FAIL %s wrap @cyc %0d: got %b want %b", t_chk, cyc, wrap, e_chk.w);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_2);
            #1;
        end
    endtask

    // Expected outputs dly edges from now (0 = state after the most recent edge).
    task automatic expect_at(input string tag, input int dly, input logic [NB-1:0] v, input logic w);
        exp_t e;
        e.due = cyc + dly;
        e.v   = v;
        e.w   = w;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic press(input logic pi, input logic pd);
        inc = pi;
        dec = pd;
        tick(9);
        inc = 1'b0;
        dec = 1'b0;
        tick(10);
    endtask

    task automatic do_load(input string tag, input logic [NB-1:0] v);
        load     = 1'b1;
        load_val = v;
        tick(1);
        load     = 1'b0;
        expect_at(tag, 0, v, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        inc      = 1'b0;
        dec      = 1'b0;
        load     = 1'b0;
        load_val = '0;
        tick(3);
        expect_at("reset", 0, 3'b000, 1'b0);
        reset = 1'b0;
        tick(1);

        // Two-cycle glitch never qualifies.
        inc = 1'b1;
        tick(2);
        inc = 1'b0;
        tick(12);
        expect_at("glitch", 0, 3'b000, 1'b0);

        // Single press: value changes exactly 7 edges after the raw input rises.
        inc = 1'b1;
        expect_at("lat_pre", 6, 3'b000, 1'b0);
        expect_at("lat_step", 7, 3'b001, 1'b0);
        expect_at("lat_hold", 9, 3'b001, 1'b0);
        tick(10);
        inc = 1'b0;
        tick(10);
        expect_at("one_step", 0, 3'b001, 1'b0);

        // Positive boundary.
        do_load("load3", 3'b011);
        expect_at("pbnd_pre", 6, 3'b011, 1'b0);
`ifdef SIGNED_STEP_SATURATE_EN
        expect_at("pbnd", 7, 3'b011, 1'b1);
        expect_at("pbnd_after", 8, 3'b011, 1'b0);
`else
        expect_at("pbnd", 7, 3'b100, 1'b1);
        expect_at("pbnd_after", 8, 3'b100, 1'b0);
`endif
        press(1'b1, 1'b0);

        // Negative boundary.
        do_load("load_m4", 3'b100);
        expect_at("nbnd_pre", 6, 3'b100, 1'b0);
`ifdef SIGNED_STEP_SATURATE_EN
        expect_at("nbnd", 7, 3'b100, 1'b1);
        expect_at("nbnd_after", 8, 3'b100, 1'b0);
`else
        expect_at("nbnd", 7, 3'b011, 1'b1);
        expect_at("nbnd_after", 8, 3'b011, 1'b0);
`endif
        press(1'b0, 1'b1);

        // Decrement through zero, then simultaneous presses cancel, then back up.
        do_load("load0", 3'b000);
        expect_at("dec_step", 7, 3'b111, 1'b0);
        press(1'b0, 1'b1);
        expect_at("both_pre", 6, 3'b111, 1'b0);
        expect_at("both", 7, 3'b111, 1'b0);
        expect_at("both_after", 12, 3'b111, 1'b0);
        press(1'b1, 1'b1);
        expect_at("inc_to0", 7, 3'b000, 1'b0);
        press(1'b1, 1'b0);

        // Load wins over the step pulse arriving on the same edge.
        inc = 1'b1;
        expect_at("ld_pre", 6, 3'b000, 1'b0);
        tick(6);
        load     = 1'b1;
        load_val = 3'b110;
        tick(1);
        load = 1'b0;
        expect_at("ld_win", 0, 3'b110, 1'b0);
        expect_at("ld_drop", 1, 3'b110, 1'b0);
        expect_at("ld_drop2", 3, 3'b110, 1'b0);
        tick(4);
        inc = 1'b0;
        tick(10);
        expect_at("ld_nostep", 0, 3'b110, 1'b0);

        // Reset while held in PRESSED, then re-qualification with the button still held.
        do_load("load1", 3'b001);
        inc = 1'b1;
        expect_at("to2", 7, 3'b010, 1'b0);
        tick(9);
        reset = 1'b1;
        tick(1);
        expect_at("rst_mid", 0, 3'b000, 1'b0);
        tick(2);
        reset = 1'b0;
        expect_at("requal_pre", 6, 3'b000, 1'b0);
        expect_at("requal", 7, 3'b001, 1'b0);
        tick(10);
        inc = 1'b0;
        tick(10);
        expect_at("requal_end", 0, 3'b001, 1'b0);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick(1);
        n_checks++;
        assert (sb_q.size() == 0) else begin
            n_err++;
            $error("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
